// File: rtl/nvme_cmd_sequencer.sv
// nvme_cmd_sequencer: request FIFO, outstanding-command limiter, completion
// skid and release FIFO between a user front end and an NVMe SSD back end.
// Optional macro NVME_CMD_SEQ_PERF_CNT_EN adds perf_* counter outputs.

package ed_mc_axi_if_pkg;
    typedef struct packed {
        logic        ssd_rq_valid;
        logic        ssd_rq_type;
        logic [63:0] ssd_rq_addr;
        logic [63:0] ssd_rq_hash;
        logic [11:0] ssd_rq_fe_id;
        logic        ssd_cp_ready;
        logic        ssd_rl_valid;
        logic [11:0] ssd_rl_be_id;
        logic        ssd_bf_ready;
        logic        ssd_ack_valid;
        logic [11:0] ssd_ack_be_id;
    } t_to_nvme_axi4;

    typedef struct packed {
        logic        ssd_rq_ready;
        logic        ssd_cp_valid;
        logic [63:0] ssd_cp_addr;
        logic [11:0] ssd_cp_fe_id;
        logic [11:0] ssd_cp_be_id;
        logic        ssd_rl_ready;
        logic        ssd_bf_valid;
        logic [63:0] ssd_bf_addr;
        logic [11:0] ssd_bf_fe_id;
        logic [11:0] ssd_bf_be_id;
        logic        ssd_ack_ready;
    } t_from_nvme_axi4;
endpackage

module nvme_cmd_sequencer
    import ed_mc_axi_if_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int RL_FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_type,
    input  logic [63:0]                        req_addr,
    input  logic [63:0]                        req_hash,
    input  logic [11:0]                        req_fe_id,
    output logic                               cpl_valid,
    input  logic                               cpl_ready,
    output logic [63:0]                        cpl_addr,
    output logic [11:0]                        cpl_fe_id,
    output logic [11:0]                        cpl_be_id,
    output logic                               bf_valid,
    input  logic                               bf_ready,
    output logic [63:0]                        bf_addr,
    output logic [11:0]                        bf_fe_id,
    output logic [11:0]                        bf_be_id,
    input  logic                               ack_valid,
    output logic                               ack_ready,
    input  logic [11:0]                        ack_be_id,
    output t_to_nvme_axi4                      to_nvme,
    input  t_from_nvme_axi4                    from_nvme,
`ifdef NVME_CMD_SEQ_PERF_CNT_EN
    output logic [31:0]                        perf_issued,
    output logic [31:0]                        perf_released,
    output logic [31:0]                        perf_stall_cycles,
`endif
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_underflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RAW = $clog2(RL_FIFO_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int EW  = 1 + 64 + 64 + 12;
    localparam logic [CW-1:0]  RQ_FULL = CW'(FIFO_DEPTH);
    localparam logic [RCW-1:0] RL_FULL = RCW'(RL_FIFO_DEPTH);
    localparam logic [OW-1:0]  MAX_C   = OW'(MAX_OUTSTANDING);

    logic [EW-1:0]  r_rq_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_rq_wp;
    logic [AW-1:0]  r_rq_rp;
    logic [CW-1:0]  r_rq_cnt;
    logic [11:0]    r_rl_mem [RL_FIFO_DEPTH];
    logic [RAW-1:0] r_rl_wp;
    logic [RAW-1:0] r_rl_rp;
    logic [RCW-1:0] r_rl_cnt;
    logic [OW-1:0]  r_outstanding;
    logic           r_err;
    logic           r_sk_full;
    logic [63:0]    r_sk_addr;
    logic [11:0]    r_sk_fe;
    logic [11:0]    r_sk_be;

    logic           w_req_ready;
    logic           w_req_hs;
    logic           w_rq_valid;
    logic           w_issue;
    logic           w_rl_full;
    logic           w_cpl_valid;
    logic           w_cpl_hs;
    logic           w_cp_ready;
    logic           w_cp_hs;
    logic           w_rl_valid;
    logic           w_release;
    logic [EW-1:0]  w_rq_head;

    // Handshake qualifiers; everything is forced idle while rst is high
    assign w_req_ready = !rst && (r_rq_cnt != RQ_FULL);
    assign w_req_hs    = req_valid && w_req_ready;
    assign w_rq_valid  = !rst && (r_rq_cnt != '0) && (r_outstanding < MAX_C);
    assign w_issue     = w_rq_valid && from_nvme.ssd_rq_ready;
    assign w_rl_full   = (r_rl_cnt == RL_FULL);
    assign w_cpl_valid = !rst && r_sk_full && !w_rl_full;
    assign w_cpl_hs    = w_cpl_valid && cpl_ready;
    assign w_cp_ready  = !rst && (!r_sk_full || w_cpl_hs);
    assign w_cp_hs     = from_nvme.ssd_cp_valid && w_cp_ready;
    assign w_rl_valid  = !rst && (r_rl_cnt != '0);
    assign w_release   = w_rl_valid && from_nvme.ssd_rl_ready;
    assign w_rq_head   = r_rq_mem[r_rq_rp];

    // Request FIFO storage
    always_ff @(posedge clk) begin
        if (w_req_hs)
            r_rq_mem[r_rq_wp] <= {req_type, req_addr, req_hash, req_fe_id};
    end

    // Request FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rq_wp  <= '0;
            r_rq_rp  <= '0;
            r_rq_cnt <= '0;
        end else begin
            if (w_req_hs)
                r_rq_wp <= r_rq_wp + AW'(1);
            if (w_issue)
                r_rq_rp <= r_rq_rp + AW'(1);
            if (w_req_hs && !w_issue)
                r_rq_cnt <= r_rq_cnt + CW'(1);
            else if (!w_req_hs && w_issue)
                r_rq_cnt <= r_rq_cnt - CW'(1);
        end
    end

    // Release FIFO storage
    always_ff @(posedge clk) begin
        if (w_cpl_hs)
            r_rl_mem[r_rl_wp] <= r_sk_be;
    end

    // Release FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rl_wp  <= '0;
            r_rl_rp  <= '0;
            r_rl_cnt <= '0;
        end else begin
            if (w_cpl_hs)
                r_rl_wp <= r_rl_wp + RAW'(1);
            if (w_release)
                r_rl_rp <= r_rl_rp + RAW'(1);
            if (w_cpl_hs && !w_release)
                r_rl_cnt <= r_rl_cnt + RCW'(1);
            else if (!w_cpl_hs && w_release)
                r_rl_cnt <= r_rl_cnt - RCW'(1);
        end
    end

    // Outstanding counter; a release with nothing live latches the error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_issue && !w_release)
                r_outstanding <= r_outstanding + OW'(1);
            else if (!w_issue && w_release && r_outstanding != '0)
                r_outstanding <= r_outstanding - OW'(1);
            if (w_release && r_outstanding == '0)
                r_err <= 1'b1;
        end
    end

    // Single-entry completion skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sk_full <= 1'b0;
            r_sk_addr <= '0;
            r_sk_fe   <= '0;
            r_sk_be   <= '0;
        end else if (w_cp_hs) begin
            r_sk_full <= 1'b1;
            r_sk_addr <= from_nvme.ssd_cp_addr;
            r_sk_fe   <= from_nvme.ssd_cp_fe_id;
            r_sk_be   <= from_nvme.ssd_cp_be_id;
        end else if (w_cpl_hs) begin
            r_sk_full <= 1'b0;
        end
    end

`ifdef NVME_CMD_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_iss;
    logic [31:0] r_perf_rel;
    logic [31:0] r_perf_stall;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_iss   <= '0;
            r_perf_rel   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue)
                r_perf_iss <= r_perf_iss + 32'd1;
            if (w_release)
                r_perf_rel <= r_perf_rel + 32'd1;
            if (r_rq_cnt != '0 && r_outstanding == MAX_C)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued       = r_perf_iss;
    assign perf_released     = r_perf_rel;
    assign perf_stall_cycles = r_perf_stall;
`endif

    // SSD-side outputs: request head, skid ready, release head, write path
    always_comb begin
        to_nvme               = '0;
        to_nvme.ssd_rq_valid  = w_rq_valid;
        to_nvme.ssd_rq_type   = w_rq_head[EW-1];
        to_nvme.ssd_rq_addr   = w_rq_head[139:76];
        to_nvme.ssd_rq_hash   = w_rq_head[75:12];
        to_nvme.ssd_rq_fe_id  = w_rq_head[11:0];
        to_nvme.ssd_cp_ready  = w_cp_ready;
        to_nvme.ssd_rl_valid  = w_rl_valid;
        to_nvme.ssd_rl_be_id  = r_rl_mem[r_rl_rp];
        to_nvme.ssd_bf_ready  = bf_ready;
        to_nvme.ssd_ack_valid = ack_valid;
        to_nvme.ssd_ack_be_id = ack_be_id;
    end

    assign req_ready     = w_req_ready;
    assign cpl_valid     = w_cpl_valid;
    assign cpl_addr      = r_sk_addr;
    assign cpl_fe_id     = r_sk_fe;
    assign cpl_be_id     = r_sk_be;
    assign bf_valid      = from_nvme.ssd_bf_valid;
    assign bf_addr       = from_nvme.ssd_bf_addr;
    assign bf_fe_id      = from_nvme.ssd_bf_fe_id;
    assign bf_be_id      = from_nvme.ssd_bf_be_id;
    assign ack_ready     = from_nvme.ssd_ack_ready;
    assign outstanding   = r_outstanding;
    assign err_underflow = r_err;

endmodule

// File: doc/nvme_cmd_sequencer.md
NVME_CMD_SEQUENCER -- requirements
Module: nvme_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, commands issued to the SSD and not yet released.
REQ-003 SHALL have parameter RL_FIFO_DEPTH, default 4, release FIFO entries (power of 2, >=2).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when both are high.
- req_type  in  1  0 = read, 1 = write.
- req_addr  in  64  SSD address.
- req_hash  in  64  hash tag.
- req_fe_id  in  12  front-end id.
- cpl_valid  out  1  completion to user.
- cpl_ready  in  1  user accepts completion.
- cpl_addr  out  64  host buffer address.
- cpl_fe_id  out  12  front-end id of the completion.
- cpl_be_id  out  12  back-end id of the completion.
- bf_valid  out  1  write buffer notice to user.
- bf_ready  in  1  user accepts buffer notice.
- bf_addr  out  64  write buffer address.
- bf_fe_id  out  12  front-end id of the buffer notice.
- bf_be_id  out  12  back-end id of the buffer notice.
- ack_valid  in  1  user write-data-ready ack.
- ack_ready  out  1  ack accepted.
- ack_be_id  in  12  back-end id being acked.
- to_nvme  out  t_to_nvme_axi4  (ed_mc_axi_if_pkg) SSD-side outputs.
- from_nvme  in  t_from_nvme_axi4  SSD-side inputs.
- outstanding  out  log2(MAX_OUTSTANDING)+1  live command count.
- err_underflow  out  1  sticky release-without-issue flag.

Function
REQ-005 Request FIFO SHALL push on req_valid&&req_ready; req_ready = (count<FIFO_DEPTH), with no bypass when full even if popping.
REQ-006 ssd_rq_valid SHALL be (FIFO non-empty)&&(outstanding<MAX_OUTSTANDING); ssd_rq_type/addr/hash/fe_id SHALL be driven from the FIFO head.
REQ-007 FIFO SHALL pop on ssd_rq_valid&&ssd_rq_ready; minimum latency from req handshake to ssd_rq_valid SHALL be 1 cycle.
REQ-008 outstanding SHALL increment on issue and decrement on the ssd_rl handshake; simultaneous issue+release SHALL leave it unchanged.
REQ-009 Completion skid register (1 entry) SHALL capture ssd_cp_* on ssd_cp_valid&&ssd_cp_ready; ssd_cp_ready = !skid_full || cpl handshake this cycle.
REQ-010 cpl_valid SHALL equal skid_full && (release FIFO not full); cpl_* data SHALL come from the skid register.
REQ-011 On cpl_valid&&cpl_ready, cpl_be_id SHALL be pushed into the release FIFO.
REQ-012 ssd_rl_valid SHALL be release FIFO non-empty; ssd_rl_be_id SHALL be its head; pop on ssd_rl_valid&&ssd_rl_ready.
REQ-013 Write path SHALL be combinational passthrough:
- bf_valid=ssd_bf_valid, bf_addr/bf_fe_id/bf_be_id from ssd_bf_*, ssd_bf_ready=bf_ready;
- ssd_ack_valid=ack_valid, ssd_ack_be_id=ack_be_id, ack_ready=ssd_ack_ready.
REQ-014 A release handshake with outstanding==0 SHALL hold outstanding at 0 and set err_underflow until reset.
REQ-015 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be tracked with an explicit count.

Reset
REQ-016 While rst=1: FIFOs empty, skid empty, outstanding=0, err_underflow=0; req_ready, cpl_valid, ssd_rq_valid and ssd_rl_valid all 0.
REQ-017 Reset asserted mid-operation SHALL discard queued requests, completions and releases without emitting further handshakes; first req_ready=1 SHALL be in the cycle after rst deasserts.

Configuration
REQ-018 With NVME_CMD_SEQ_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_issued, perf_released and perf_stall_cycles:
- each reset to 0 and wrapping at 2^32;
- perf_stall_cycles increments each cycle the FIFO is non-empty and outstanding==MAX_OUTSTANDING.
Without the macro these ports and their counters SHALL not exist.

Verification
REQ-019 Push 3 reads (fe_id 1,2,3) with ssd_rq_ready=1 -> ssd_rq issues fe_id 1,2,3 in order on consecutive cycles; outstanding=3.
REQ-020 ssd_rq_ready=0, push 8 requests -> req_ready=0 after the 8th; the 9th is held until one pop.
REQ-021 Issue 16 with no release -> ssd_rq_valid=0 while FIFO is non-empty; one release -> next issue the following cycle, outstanding back to 16.
REQ-022 ssd_cp be_id 0x05 with cpl_ready=1 -> cpl_be_id=0x05 -> ssd_rl_be_id=0x05 -> outstanding decrements by 1.
REQ-023 Hold ssd_rl_ready=0 and complete 5 commands -> release FIFO holds 4; 5th cpl_valid=0 and ssd_cp_ready=0 until a release drains.
REQ-024 Force ssd_rl handshake at outstanding=0 -> outstanding stays 0, err_underflow=1 until rst.
